// File: rtl/bitrev_reorder_buffer_pkg.sv
// Shared definitions for the bit-reversed reorder buffer and its
// bit-reversed writer: default frame geometry, bank state names and the
// bit-reversal index function.
package bitrev_reorder_buffer_pkg;

    localparam int DEFAULT_N         = 3;
    localparam int DEFAULT_FRAME_LEN = 1 << DEFAULT_N;

    // Life cycle of one ping-pong bank; derived from full flag plus selects.
    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Number of samples in a frame of 2^n samples.
    function automatic int unsigned frame_len(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // Reverse the low n bits of k; bits above n are returned as zero.
    function automatic logic [31:0] bitrev(input int unsigned n, input logic [31:0] k);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < n; i++) begin
            r[i] = k[n-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_reorder_buffer_bank.sv
// One 2^N x DW sample bank: a single write port and an asynchronous read
// port so the selected output sample is visible in the same cycle as its
// read address. The array carries no reset; its contents only matter once
// the bank's full flag says a whole frame was written.
module bitrev_bank
    import bitrev_reorder_buffer_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [N-1:0]  waddr,
    input  logic [DW-1:0] wdata,
    input  logic [N-1:0]  raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<N)-1];

    // Store an accepted sample at its natural-order address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bitrev_reorder_buffer.sv
// Ping-pong reorder buffer: frames of 2^N samples arrive in bit-reversed
// index order and leave in natural order. One bank fills while the other
// drains. in_ready depends only on registered state, never on out_ready,
// so freeing a bank costs one bubble on the input side.
module bitrev_reorder_buffer
    import bitrev_reorder_buffer_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [N-1:0]  out_index,
    output logic          out_last
);

    localparam logic [N-1:0] CNT_MAX = '1;

    logic [1:0]    full_reg, full_next;
    logic          wsel_reg, wsel_next;
    logic          rsel_reg, rsel_next;
    logic [N-1:0]  wcnt_reg, wcnt_next;
    logic [N-1:0]  rcnt_reg, rcnt_next;

    bank_state_e   bank_state [2];
    logic [DW-1:0] bank_rdata [2];
    logic [N-1:0]  waddr;
    logic          wr_fire;
    logic          rd_fire;

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    // The k-th sample of a frame belongs at natural index bitrev(k).
    assign waddr   = N'(bitrev(N, 32'(wcnt_reg)));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            bitrev_bank #(
                .N  (N),
                .DW (DW)
            ) u_bank (
                .clk   (clk),
                .we    (wr_fire && (wsel_reg == 1'(gi))),
                .waddr (waddr),
                .wdata (in_data),
                .raddr (rcnt_reg),
                .rdata (bank_rdata[gi])
            );
        end
    endgenerate

    // Control state register; reset discards any partial or complete frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= '0;
            wsel_reg <= 1'b0;
            rsel_reg <= 1'b0;
            wcnt_reg <= '0;
            rcnt_reg <= '0;
        end else begin
            full_reg <= full_next;
            wsel_reg <= wsel_next;
            rsel_reg <= rsel_next;
            wcnt_reg <= wcnt_next;
            rcnt_reg <= rcnt_next;
        end
    end

    // Next state: a write wrap fills bank wsel, a read wrap frees bank rsel.
    // The two can never target the same bank, so both apply together.
    always_comb begin
        full_next = full_reg;
        wsel_next = wsel_reg;
        rsel_next = rsel_reg;
        wcnt_next = wcnt_reg;
        rcnt_next = rcnt_reg;
        if (wr_fire) begin
            wcnt_next = wcnt_reg + N'(1);
            if (wcnt_reg == CNT_MAX) begin
                full_next[wsel_reg] = 1'b1;
                wsel_next           = ~wsel_reg;
            end
        end
        if (rd_fire) begin
            rcnt_next = rcnt_reg + N'(1);
            if (rcnt_reg == CNT_MAX) begin
                full_next[rsel_reg] = 1'b0;
                rsel_next           = ~rsel_reg;
            end
        end
    end

    // Outputs: per-bank state decoded from flags/selects, then handshakes.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            if (full_reg[b]) begin
                bank_state[b] = (rsel_reg == 1'(b) && rcnt_reg != '0) ? BANK_DRAINING : BANK_FULL;
            end else if (wsel_reg == 1'(b)) begin
                bank_state[b] = BANK_FILLING;
            end else begin
                bank_state[b] = BANK_EMPTY;
            end
        end
        in_ready  = (bank_state[wsel_reg] == BANK_FILLING);
        out_valid = (bank_state[rsel_reg] == BANK_FULL) || (bank_state[rsel_reg] == BANK_DRAINING);
        out_data  = bank_rdata[rsel_reg];
        out_index = rcnt_reg;
        out_last  = out_valid && (rcnt_reg == CNT_MAX);
    end

endmodule
